image_loader: RTL

Upstream feeder for the forward-propagation state machine. It accepts one 28x28 image as a stream of 784 8-bit pixels over a valid/ready handshake and stores it in an internal pixel buffer. It then raises `Compute` and tracks the `R` handshake until inference completes. While inference runs, the buffer stays read-only and is served to the layer-1 neurons through a registered read port.

---
 rtl/mnist_pkg.sv | 16 +
 rtl/pixel_ram.sv | 35 +++
 rtl/image_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference front end.
// Frame geometry and the image loader state encoding.
package mnist_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned COUNT_W    = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module pixel_ram #(
  parameter int unsigned DEPTH  = 784,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/image_loader.sv
// Loads one 28x28 frame over valid/ready, then requests and tracks inference.
// The pixel buffer is read-only to the writer while a frame is held.
module image_loader #(
  parameter int unsigned NUM_PIXELS = mnist_pkg::NUM_PIXELS,
  parameter int unsigned PIX_W      = mnist_pkg::PIX_W,
  parameter int unsigned ADDR_W     = mnist_pkg::ADDR_W
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         PixValid,
  input  logic [PIX_W-1:0]             PixData,
  output logic                         PixReady,
  input  logic [ADDR_W-1:0]            RdAddr,
  output logic [PIX_W-1:0]             RdData,
  output logic                         Compute,
  input  logic                         R,
  output logic                         Busy,
  output logic                         FrameDone,
  output logic [mnist_pkg::COUNT_W-1:0] FrameCount
);

  import mnist_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t        state, state_nxt;
  logic [ADDR_W-1:0]    wr_ptr, wr_ptr_nxt;
  logic [COUNT_W-1:0]   count_nxt;
  logic                 done_nxt;
  logic                 ready_nxt, compute_nxt, busy_nxt;
  logic                 wr_en_c;

  // State, pointer, counter and all outputs are registered together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      FrameCount <= '0;
      FrameDone  <= 1'b0;
      PixReady   <= 1'b1;
      Compute    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      FrameCount <= count_nxt;
      FrameDone  <= done_nxt;
      PixReady   <= ready_nxt;
      Compute    <= compute_nxt;
      Busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = FrameCount;
    done_nxt   = 1'b0;
    wr_en_c    = 1'b0;

    case (state)
      ST_FILL: begin
        // R is deliberately ignored while filling.
        if (PixValid) begin
          wr_en_c = 1'b1;
          if (wr_ptr == LAST_ADDR) begin
            wr_ptr_nxt = '0;
            state_nxt  = ST_REQ;
          end else begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
          end
        end
      end
      ST_REQ: begin
        if (!R) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (R) begin
          state_nxt = ST_FILL;
          done_nxt  = 1'b1;
          count_nxt = FrameCount + COUNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase

    // Outputs decode the upcoming state so they appear registered.
    ready_nxt   = (state_nxt == ST_FILL);
    compute_nxt = (state_nxt == ST_REQ);
    busy_nxt    = (state_nxt != ST_FILL);
  end

  pixel_ram #(
    .DEPTH  (NUM_PIXELS),
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_pixel_ram (
    .clk     (Clk),
    .rst     (Reset),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (PixData),
    .rd_addr (RdAddr),
    .rd_data (RdData)
  );

endmodule
